fifo_single_clock_ram_ext: RTL and testbench

Single-clock FIFO on inferred block RAM with a 1-cycle registered read port. It generalises the existing block-RAM FIFO:
- any DEPTH (power of 2 not required)
- both normal and first-word-fall-through (FWFT) read modes
- programmable almost-full / almost-empty flags
- write accepted on a full FIFO when a read is accepted in the same cycle

It sits between producer and consumer datapaths inside one clock domain.

---
 rtl/fifo_single_clock_ram_ext.sv | 145 ++++++++++++++
 tb/tb_fifo_single_clock_ram_ext.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_single_clock_ram_ext.sv
// Single-clock FIFO on inferred block RAM with registered read port; normal or FWFT read mode.
// Define FIFO_STATS_EN to add high-water mark and rejected-request counters.
`timescale 1ns/1ps
module fifo_single_clock_ram_ext #(
   parameter string FWFT_MODE  = "FALSE",
   parameter int    DEPTH      = 6,
   parameter int    DEPTH_W    = $clog2(DEPTH+1),
   parameter int    DATA_W     = 16,
   parameter int    AFULL_LVL  = DEPTH-1,
   parameter int    AEMPTY_LVL = 1,
   parameter string RAM_STYLE  = "block"
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               w_req,
   input  logic [DATA_W-1:0]  w_data,
   input  logic               r_req,
   output logic [DATA_W-1:0]  r_data,
   output logic [DEPTH_W-1:0] cnt,
   output logic               empty,
   output logic               full,
   output logic               afull,
   output logic               aempty,
   output logic               fail,
   input  logic               stats_clr,
   output logic [DEPTH_W-1:0] max_cnt,
   output logic [15:0]        ovf_cnt,
   output logic [15:0]        unf_cnt
);

   localparam int                 PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam bit                 FWFT     = (FWFT_MODE == "TRUE");
   localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH-1);
   localparam logic [DEPTH_W-1:0] DEPTH_C  = DEPTH_W'(DEPTH);
   localparam logic [DEPTH_W-1:0] AFULL_C  = DEPTH_W'(AFULL_LVL);
   localparam logic [DEPTH_W-1:0] AEMPTY_C = DEPTH_W'(AEMPTY_LVL);

   (* ram_style = RAM_STYLE *) logic [DATA_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0]  r_data_q;
   logic               dout_vld_q, dout_vld_d;
   logic [DEPTH_W-1:0] ram_cnt;
   logic               rd_ok, wr_ok, ram_rd;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // In FWFT mode the RAM output register doubles as the presented word, so
   // cnt covers it and the RAM itself holds cnt minus that staged word.
   assign empty   = FWFT ? !dout_vld_q : (cnt_q == '0);
   assign ram_cnt = cnt_q - DEPTH_W'(FWFT && dout_vld_q);
   assign full    = (cnt_q == DEPTH_C);
   assign afull   = (cnt_q >= AFULL_C);
   assign aempty  = (cnt_q <= AEMPTY_C);
   assign rd_ok   = r_req && !empty;
   assign wr_ok   = w_req && (!full || rd_ok);
   assign fail    = (r_req && !rd_ok) || (w_req && !wr_ok);
   assign ram_rd  = FWFT ? ((ram_cnt != '0) && (!dout_vld_q || rd_ok)) : rd_ok;
   assign cnt     = cnt_q;
   assign r_data  = r_data_q;

   always_comb begin
      cnt_d      = cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      dout_vld_d = dout_vld_q;
      if (wr_ok && !rd_ok) begin
         cnt_d = cnt_q + DEPTH_W'(1);
      end else if (!wr_ok && rd_ok) begin
         cnt_d = cnt_q - DEPTH_W'(1);
      end
      if (wr_ok) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (ram_rd) begin
         rd_ptr_d   = ptr_inc(rd_ptr_q);
         dout_vld_d = 1'b1;
      end else if (rd_ok) begin
         dout_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= w_data;
      end
   end

   // Read-first: a simultaneous write to the same address returns the old word.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         r_data_q   <= '0;
         dout_vld_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         dout_vld_q <= dout_vld_d;
         if (ram_rd) begin
            r_data_q <= mem_q[rd_ptr_q];
         end
      end
   end

`ifdef FIFO_STATS_EN
   logic [DEPTH_W-1:0] max_cnt_q;
   logic [15:0]        ovf_cnt_q, unf_cnt_q;

   always_ff @(posedge clk) begin
      if (!nrst || stats_clr) begin
         max_cnt_q <= '0;
         ovf_cnt_q <= '0;
         unf_cnt_q <= '0;
      end else begin
         if (cnt_d > max_cnt_q) begin
            max_cnt_q <= cnt_d;
         end
         if (w_req && !wr_ok && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
         end
         if (r_req && !rd_ok && (unf_cnt_q != 16'hFFFF)) begin
            unf_cnt_q <= unf_cnt_q + 16'd1;
         end
      end
   end

   assign max_cnt = max_cnt_q;
   assign ovf_cnt = ovf_cnt_q;
   assign unf_cnt = unf_cnt_q;
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr;
   assign max_cnt = '0;
   assign ovf_cnt = '0;
   assign unf_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_single_clock_ram_ext.sv
// Scoreboard bench for fifo_single_clock_ram_ext: one normal-mode and one FWFT instance, DEPTH=6.
`timescale 1ns/1ps
module tb_fifo_single_clock_ram_ext;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   logic        n_w_req = 1'b0, n_r_req = 1'b0, n_stats_clr = 1'b0;
   logic [15:0] n_w_data = '0;
   logic [15:0] n_r_data, n_ovf, n_unf;
   logic [2:0]  n_cnt, n_max;
   logic        n_empty, n_full, n_afull, n_aempty, n_fail;

   logic        f_w_req = 1'b0, f_r_req = 1'b0, f_stats_clr = 1'b0;
   logic [15:0] f_w_data = '0;
   logic [15:0] f_r_data, f_ovf, f_unf;
   logic [2:0]  f_cnt, f_max;
   logic        f_empty, f_full, f_afull, f_aempty, f_fail;

   fifo_single_clock_ram_ext #(.FWFT_MODE("FALSE"), .DEPTH(6), .DATA_W(16)) u_norm (
      .clk(clk), .nrst(nrst), .w_req(n_w_req), .w_data(n_w_data), .r_req(n_r_req),
      .r_data(n_r_data), .cnt(n_cnt), .empty(n_empty), .full(n_full), .afull(n_afull),
      .aempty(n_aempty), .fail(n_fail), .stats_clr(n_stats_clr), .max_cnt(n_max),
      .ovf_cnt(n_ovf), .unf_cnt(n_unf));

   fifo_single_clock_ram_ext #(.FWFT_MODE("TRUE"), .DEPTH(6), .DATA_W(16)) u_fwft (
      .clk(clk), .nrst(nrst), .w_req(f_w_req), .w_data(f_w_data), .r_req(f_r_req),
      .r_data(f_r_data), .cnt(f_cnt), .empty(f_empty), .full(f_full), .afull(f_afull),
      .aempty(f_aempty), .fail(f_fail), .stats_clr(f_stats_clr), .max_cnt(f_max),
      .ovf_cnt(f_ovf), .unf_cnt(f_unf));

   int chk_cnt = 0;
   int err_cnt = 0;

   logic [15:0] m_q[$];
   logic [15:0] exp_q[$];
   logic [15:0] fw_exp_q[$];
   int          m_max = 0, m_ovf = 0, m_unf = 0;
   logic        n_pend = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Normal-mode monitor: a read accepted in cycle k shows on r_data after the next edge.
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (n_pend) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
               err_cnt++;
               $display("FAIL n_rdata: read with no expected word, got %0h", n_r_data);
            end else begin
               e = exp_q.pop_front();
               if (n_r_data !== e) begin
                  err_cnt++;
                  $display("FAIL n_rdata: got %0h expected %0h at %0t", n_r_data, e, $time);
               end
            end
         end
         n_pend = n_r_req && !n_empty && nrst;
      end
   end

   // FWFT monitor: the presented word is checked in each cycle it is popped.
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (f_r_req && !f_empty && nrst) begin
            chk_cnt++;
            if (fw_exp_q.size() == 0) begin
               err_cnt++;
               $display("FAIL f_rdata: pop with no expected word, got %0h", f_r_data);
            end else begin
               e = fw_exp_q.pop_front();
               if (f_r_data !== e) begin
                  err_cnt++;
                  $display("FAIL f_rdata: got %0h expected %0h at %0t", f_r_data, e, $time);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic n_step(input logic w, input logic [15:0] d, input logic r);
      logic rok, wok;
      int   sz;
      n_w_req  = w;
      n_w_data = d;
      n_r_req  = r;
      #1;
      sz  = m_q.size();
      rok = r && (sz != 0);
      wok = w && ((sz < 6) || rok);
      chk("n_cnt", n_cnt, sz);
      chk("n_empty", n_empty, sz == 0);
      chk("n_full", n_full, sz == 6);
      chk("n_afull", n_afull, sz >= 5);
      chk("n_aempty", n_aempty, sz <= 1);
      chk("n_fail", n_fail, (r && !rok) || (w && !wok));
`ifdef FIFO_STATS_EN
      chk("n_max_cnt", n_max, m_max);
      chk("n_ovf_cnt", n_ovf, m_ovf);
      chk("n_unf_cnt", n_unf, m_unf);
`endif
      if (rok) exp_q.push_back(m_q.pop_front());
      if (wok) m_q.push_back(d);
      if (n_stats_clr) begin
         m_max = 0; m_ovf = 0; m_unf = 0;
      end else begin
         if (m_q.size() > m_max) m_max = m_q.size();
         if (w && !wok && m_ovf < 65535) m_ovf++;
         if (r && !rok && m_unf < 65535) m_unf++;
      end
      @(posedge clk); #1;
      n_w_req = 1'b0;
      n_r_req = 1'b0;
   endtask

   task automatic do_reset();
      n_w_req = 1'b0; n_r_req = 1'b0; f_w_req = 1'b0; f_r_req = 1'b0;
      nrst = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      nrst = 1'b1;
      m_q.delete();
      m_max = 0; m_ovf = 0; m_unf = 0;
   endtask

   initial begin
      do_reset();
      chk("n_rdata_rst", n_r_data, 16'h0000);
      chk("f_empty_rst", f_empty, 1'b1);
      chk("f_rdata_rst", f_r_data, 16'h0000);

      // Fill, overflow, drain
      for (int i = 1; i <= 6; i++) n_step(1'b1, 16'(i), 1'b0);
      n_step(1'b1, 16'h0007, 1'b0);
      for (int i = 0; i < 6; i++) n_step(1'b0, 16'h0000, 1'b1);
      n_step(1'b0, 16'h0000, 1'b0);

      // Streaming across pointer wrap
      for (int i = 0; i < 4; i++) n_step(1'b1, 16'(16'h0100 + i), 1'b0);
      for (int i = 0; i < 20; i++) n_step(1'b1, 16'(16'h0104 + i), 1'b1);
      for (int i = 0; i < 4; i++) n_step(1'b0, 16'h0000, 1'b1);
      n_step(1'b0, 16'h0000, 1'b0);

      // Simultaneous read/write on full
      for (int i = 0; i < 6; i++) n_step(1'b1, 16'(16'h0200 + i), 1'b0);
      n_step(1'b1, 16'hAAAA, 1'b1);
      for (int i = 0; i < 6; i++) n_step(1'b0, 16'h0000, 1'b1);
      n_step(1'b0, 16'h0000, 1'b0);

      // Simultaneous read/write on empty
      n_step(1'b1, 16'h1234, 1'b1);
      n_step(1'b0, 16'h0000, 1'b1);
      n_step(1'b0, 16'h0000, 1'b0);

      // Reset with words held
      for (int i = 1; i <= 3; i++) n_step(1'b1, 16'(16'h0300 + i), 1'b0);
      chk("n_cnt_pre_rst", n_cnt, 3'd3);
      do_reset();
      chk("n_cnt_post_rst", n_cnt, 3'd0);
      chk("n_empty_post_rst", n_empty, 1'b1);
      chk("n_aempty_post_rst", n_aempty, 1'b1);
      chk("n_rdata_post_rst", n_r_data, 16'h0000);
`ifdef FIFO_STATS_EN
      chk("n_max_post_rst", n_max, 3'd0);
      chk("n_ovf_post_rst", n_ovf, 16'd0);
`endif
      n_step(1'b1, 16'h0055, 1'b0);
      n_step(1'b0, 16'h0000, 1'b1);
      n_step(1'b0, 16'h0000, 1'b0);

      // Statistics clear, with a rejected read in the same cycle
      n_step(1'b0, 16'h0000, 1'b1);
      n_step(1'b1, 16'h0077, 1'b0);
      n_step(1'b0, 16'h0000, 1'b1);
      n_stats_clr = 1'b1;
      n_step(1'b1, 16'h0078, 1'b1);
      n_stats_clr = 1'b0;
      n_step(1'b0, 16'h0000, 1'b1);
      n_step(1'b0, 16'h0000, 1'b0);
`ifndef FIFO_STATS_EN
      chk("n_max_tied", n_max, 3'd0);
      chk("n_ovf_tied", n_ovf, 16'd0);
      chk("n_unf_tied", n_unf, 16'd0);
`endif

      // FWFT: write-to-empty latency
      f_w_req = 1'b1; f_w_data = 16'h00A5; fw_exp_q.push_back(16'h00A5);
      #1 chk("f_empty_T", f_empty, 1'b1);
      @(posedge clk); #1; f_w_req = 1'b0;
      chk("f_cnt_T1", f_cnt, 3'd1);
      chk("f_empty_T1", f_empty, 1'b1);
      @(posedge clk); #1;
      chk("f_empty_T2", f_empty, 1'b0);
      chk("f_rdata_T2", f_r_data, 16'h00A5);
      f_r_req = 1'b1;
      #1 chk("f_fail_pop", f_fail, 1'b0);
      @(posedge clk); #1; f_r_req = 1'b0;
      chk("f_empty_last_pop", f_empty, 1'b1);
      chk("f_cnt_last_pop", f_cnt, 3'd0);
      chk("f_rdata_hold", f_r_data, 16'h00A5);
      f_r_req = 1'b1;
      #1 chk("f_fail_underflow", f_fail, 1'b1);
      @(posedge clk); #1; f_r_req = 1'b0;

      // FWFT: back-to-back pops
      for (int i = 0; i < 5; i++) begin
         f_w_req = 1'b1; f_w_data = 16'(16'h00B1 + i); fw_exp_q.push_back(16'(16'h00B1 + i));
         @(posedge clk); #1;
      end
      f_w_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("f_cnt_5", f_cnt, 3'd5);
      for (int i = 0; i < 5; i++) begin
         f_r_req = 1'b1;
         #1 chk("f_empty_burst", f_empty, 1'b0);
         @(posedge clk); #1;
      end
      f_r_req = 1'b0;
      chk("f_empty_burst_end", f_empty, 1'b1);
      chk("f_cnt_burst_end", f_cnt, 3'd0);
      chk("f_rdata_burst_hold", f_r_data, 16'h00B5);

      // FWFT: simultaneous read/write on full
      for (int i = 0; i < 6; i++) begin
         f_w_req = 1'b1; f_w_data = 16'(16'h00C0 + i); fw_exp_q.push_back(16'(16'h00C0 + i));
         @(posedge clk); #1;
      end
      f_w_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("f_full", f_full, 1'b1);
      chk("f_afull", f_afull, 1'b1);
      chk("f_cnt_full", f_cnt, 3'd6);
      f_w_req = 1'b1; f_w_data = 16'hCCCC; f_r_req = 1'b1; fw_exp_q.push_back(16'hCCCC);
      #1 chk("f_fail_full_rw", f_fail, 1'b0);
      @(posedge clk); #1; f_w_req = 1'b0; f_r_req = 1'b0;
      chk("f_cnt_full_rw", f_cnt, 3'd6);
      for (int i = 0; i < 6; i++) begin
         f_r_req = 1'b1;
         #1 chk("f_empty_drain", f_empty, 1'b0);
         @(posedge clk); #1;
      end
      f_r_req = 1'b0;
      chk("f_empty_drained", f_empty, 1'b1);
      chk("f_rdata_last", f_r_data, 16'hCCCC);

      repeat (2) @(posedge clk);
      #1;
      chk("n_exp_q_drained", exp_q.size(), 0);
      chk("f_exp_q_drained", fw_exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
      $finish;
   end

endmodule
